// File: rtl/qbus_areg_block.sv
// QBUS I/O-page register slave: `count` consecutive 16-bit read/write registers
// starting at word address `addr`. Handles DATI, DATO(B) and DATIO(B); all bus
// inputs are active-high, already inverted by the transceiver layer.
module qbus_areg_block #(
    parameter logic [12:0] addr  = 13'o17774,
    parameter int unsigned count = 1,
    parameter logic [15:0] init  = 16'o123456
) (
    input  logic        clk,
    input  logic        reset,
    output logic        DALtx,
    inout  wire  [21:0] DAL,
    output logic        TRPLY,
    input  logic        RDIN,
    input  logic        RDOUT,
    input  logic        RSYNC,
    input  logic        RBS7,
    input  logic        RWTBT
);

    typedef enum logic [2:0] {StIdle, StSel, StMiss, StRead, StWrite} stateType;

    stateType    state;
    logic [15:0] regFile [count];
    logic [3:0]  idx;
    logic        byteHi;
    logic [15:0] dalOut;
    logic [15:0] rdData;

    // Synchroniser stages: {sync, din, dout, bs7, wtbt}
    logic [4:0]  syncA;
    logic [4:0]  syncB;
    logic [2:0]  prevLvl;

    logic syncLvl, dinLvl, doutLvl, bs7Lvl, wtbtLvl;
    logic syncRise, dinRise, doutRise;

    logic [11:0] offset;
    logic        hit;

    // Address bits above the I/O page are deliberately ignored
    logic unusedHigh;
    assign unusedHigh = ^DAL[21:13];

    assign {syncLvl, dinLvl, doutLvl, bs7Lvl, wtbtLvl} = syncB;
    assign syncRise = syncLvl & ~prevLvl[2];
    assign dinRise  = dinLvl  & ~prevLvl[1];
    assign doutRise = doutLvl & ~prevLvl[0];

    // Offset wraps modulo 4096, so addresses below the base fail the range test
    assign offset = DAL[12:1] - addr[12:1];
    assign hit    = bs7Lvl && (offset < 12'(count));

    // Only this block's own data ever reaches the bus; high-Z otherwise
    assign DAL = DALtx ? {6'b0, dalOut} : 22'bz;

    // Two-flop synchronisers plus a previous-level stage for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            syncA   <= '0;
            syncB   <= '0;
            prevLvl <= '0;
        end else begin
            syncA   <= {RSYNC, RDIN, RDOUT, RBS7, RWTBT};
            syncB   <= syncA;
            prevLvl <= syncB[4:2];
        end
    end

    // Read mux over the latched register index
    always_comb begin
        rdData = '0;
        for (int n = 0; n < count; n++) begin
            if (idx == 4'(n)) begin
                rdData = regFile[n];
            end
        end
    end

    // Bus cycle FSM, register file updates and registered bus outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= StIdle;
            DALtx  <= 1'b0;
            TRPLY  <= 1'b0;
            dalOut <= '0;
            idx    <= '0;
            byteHi <= 1'b0;
            for (int n = 0; n < count; n++) begin
                regFile[n] <= init;
            end
        end else if (state != StIdle && !syncLvl) begin
            // SYNC dropped: end of bus cycle, release everything
            state <= StIdle;
            DALtx <= 1'b0;
            TRPLY <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    DALtx <= 1'b0;
                    TRPLY <= 1'b0;
                    if (syncRise) begin
                        if (hit) begin
                            state  <= StSel;
                            idx    <= offset[3:0];
                            byteHi <= DAL[0];
                        end else begin
                            state <= StMiss;
                        end
                    end
                end
                StSel: begin
                    // DIN takes priority when both strobes rise together
                    if (dinRise) begin
                        state  <= StRead;
                        dalOut <= rdData;
                        DALtx  <= 1'b1;
                    end else if (doutRise) begin
                        state <= StWrite;
                        TRPLY <= 1'b1;
                        for (int n = 0; n < count; n++) begin
                            if (idx == 4'(n)) begin
                                if (!wtbtLvl) begin
                                    regFile[n] <= DAL[15:0];
                                end else if (byteHi) begin
                                    regFile[n][15:8] <= DAL[15:8];
                                end else begin
                                    regFile[n][7:0] <= DAL[7:0];
                                end
                            end
                        end
                    end
                end
                StRead: begin
                    // Data has been on the bus for a clock before RPLY rises
                    if (!dinLvl) begin
                        state <= StSel;
                        TRPLY <= 1'b0;
                        DALtx <= 1'b0;
                    end else begin
                        TRPLY <= 1'b1;
                    end
                end
                StWrite: begin
                    if (!doutLvl) begin
                        state <= StSel;
                        TRPLY <= 1'b0;
                    end
                end
                StMiss: begin
                    // Stay silent until SYNC drops; master times out with NXM
                end
                default: begin
                    state <= StIdle;
                    DALtx <= 1'b0;
                    TRPLY <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qbus_areg_block.sv
// Bench for qbus_areg_block: two instances (17774 and 17772) sharing the bus,
// table-driven bus cycles with a read-data scoreboard plus a mid-read reset.
module tb_qbus_areg_block;

    logic        clk = 1'b0;
    logic        reset;
    logic        dinIn, doutIn, syncIn, bs7In, wtbtIn;
    logic        tbDrv;
    logic [21:0] tbDal;
    wire  [21:0] DAL;
    logic        dalTx0, dalTx1, rply0, rply1;
    logic        rply, dalTx;

    int errors = 0;
    int checks = 0;
    logic [15:0] expQ [$];

    typedef struct {
        int          op;     // 0 DATI, 1 DATO(B), 2 DATIO(B)
        logic [21:0] a;
        logic        bs7;
        logic        wtbt;
        logic [15:0] wdata;
        logic        reply;
        logic [15:0] rdata;
    } vecT;

    vecT tbl [11];

    assign DAL   = tbDrv ? tbDal : 22'bz;
    assign rply  = rply0 | rply1;
    assign dalTx = dalTx0 | dalTx1;

    always #10 clk = ~clk;

    qbus_areg_block #(.addr(13'o17774), .count(1), .init(16'o123456)) u0 (
        .clk(clk), .reset(reset), .DALtx(dalTx0), .DAL(DAL), .TRPLY(rply0),
        .RDIN(dinIn), .RDOUT(doutIn), .RSYNC(syncIn), .RBS7(bs7In), .RWTBT(wtbtIn)
    );

    qbus_areg_block #(.addr(13'o17772), .count(1), .init(16'o123456)) u1 (
        .clk(clk), .reset(reset), .DALtx(dalTx1), .DAL(DAL), .TRPLY(rply1),
        .RDIN(dinIn), .RDOUT(doutIn), .RSYNC(syncIn), .RBS7(bs7In), .RWTBT(wtbtIn)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0o expected %0o", name, act, exp);
        end
    endtask

    function automatic vecT mk(input int op, input logic [21:0] a, input logic bs7,
                               input logic wtbt, input logic [15:0] wd,
                               input logic rep, input logic [15:0] rd);
        vecT v;
        v.op = op; v.a = a; v.bs7 = bs7; v.wtbt = wtbt;
        v.wdata = wd; v.reply = rep; v.rdata = rd;
        return v;
    endfunction

    task automatic addressPhase(input logic [21:0] a, input logic bs7);
        tbDal = a;
        tbDrv = 1'b1;
        bs7In = bs7;
        repeat (2) @(negedge clk);
        syncIn = 1'b1;
        repeat (6) @(negedge clk);
        tbDrv = 1'b0;
        bs7In = 1'b0;
    endtask

    task automatic waitDrop(input string name);
        logic gone;
        gone = 1'b0;
        for (int i = 0; i < 10 && !gone; i++) begin
            @(negedge clk);
            if (!rply && !dalTx) gone = 1'b1;
        end
        check(name, gone, 1'b1);
    endtask

    task automatic readPhase(input vecT v);
        time         tDin;
        logic        seen, bad;
        logic [15:0] exp;
        if (v.reply) expQ.push_back(v.rdata);
        seen = 1'b0;
        bad  = 1'b0;
        dinIn = 1'b1;
        tDin = $time;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            if (rply) seen = 1'b1;
            if (rply || dalTx) bad = 1'b1;
        end
        if (v.reply) begin
            exp = expQ.pop_front();
            check("read_rply_seen", seen, 1'b1);
            if (seen) begin
                check("read_rply_150ns", ($time - tDin) <= 150, 1'b1);
                check("read_dal_tx", dalTx, 1'b1);
                check("read_data", DAL, {6'b0, exp});
            end
        end else begin
            check("nxm_silent", bad, 1'b0);
        end
        dinIn = 1'b0;
        if (seen) waitDrop("read_rply_drop");
    endtask

    task automatic writePhase(input vecT v);
        logic seen;
        seen = 1'b0;
        tbDal  = {6'b0, v.wdata};
        tbDrv  = 1'b1;
        wtbtIn = v.wtbt;
        doutIn = 1'b1;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            if (rply) seen = 1'b1;
        end
        check("write_rply_seen", seen, v.reply);
        doutIn = 1'b0;
        if (seen) waitDrop("write_rply_drop");
        tbDrv  = 1'b0;
        wtbtIn = 1'b0;
    endtask

    task automatic busCycle(input vecT v);
        addressPhase(v.a, v.bs7);
        if (v.op != 1) readPhase(v);
        if (v.op != 0) writePhase(v);
        syncIn = 1'b0;
        repeat (4) @(negedge clk);
        check("end_idle", {rply, dalTx}, 2'b00);
    endtask

    initial begin
        logic seen;
        tbl[0]  = mk(0, 22'o17777774, 1'b1, 1'b0, 16'o0,      1'b1, 16'o123456);
        tbl[1]  = mk(0, 22'o17777770, 1'b1, 1'b0, 16'o0,      1'b0, 16'o0);
        tbl[2]  = mk(0, 22'o00017774, 1'b1, 1'b0, 16'o0,      1'b1, 16'o123456);
        tbl[3]  = mk(0, 22'o17777774, 1'b0, 1'b0, 16'o0,      1'b0, 16'o0);
        tbl[4]  = mk(1, 22'o17777774, 1'b1, 1'b0, 16'o054321, 1'b1, 16'o0);
        tbl[5]  = mk(0, 22'o17777774, 1'b1, 1'b0, 16'o0,      1'b1, 16'o054321);
        tbl[6]  = mk(0, 22'o17777772, 1'b1, 1'b0, 16'o0,      1'b1, 16'o123456);
        tbl[7]  = mk(2, 22'o17777772, 1'b1, 1'b0, 16'o054545, 1'b1, 16'o123456);
        tbl[8]  = mk(0, 22'o17777772, 1'b1, 1'b0, 16'o0,      1'b1, 16'o054545);
        tbl[9]  = mk(1, 22'o17777773, 1'b1, 1'b1, 16'o177400, 1'b1, 16'o0);
        tbl[10] = mk(0, 22'o17777772, 1'b1, 1'b0, 16'o0,      1'b1, 16'o177545);

        reset = 1'b1;
        dinIn = 1'b0; doutIn = 1'b0; syncIn = 1'b0; bs7In = 1'b0; wtbtIn = 1'b0;
        tbDrv = 1'b0; tbDal = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {rply, dalTx}, 2'b00);
        check("reset_dal_released", (DAL === 22'bz), 1'b1);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 11; i++) busCycle(tbl[i]);

        // Reset in the middle of a read of 054321 from 17774
        addressPhase(22'o17777774, 1'b1);
        dinIn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            if (rply) seen = 1'b1;
        end
        check("midread_rply_seen", seen, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("midread_reset_outputs", {rply, dalTx}, 2'b00);
        reset = 1'b0;
        dinIn = 1'b0;
        syncIn = 1'b0;
        repeat (4) @(negedge clk);

        busCycle(mk(0, 22'o17777774, 1'b1, 1'b0, 16'o0, 1'b1, 16'o123456));
        busCycle(mk(0, 22'o17777772, 1'b1, 1'b0, 16'o0, 1'b1, 16'o123456));
        // Low-byte write on the even address keeps the high byte of 0xA72E
        busCycle(mk(1, 22'o17777774, 1'b1, 1'b1, 16'h00AA, 1'b1, 16'o0));
        busCycle(mk(0, 22'o17777774, 1'b1, 1'b0, 16'o0, 1'b1, 16'hA7AA));

        check("scoreboard_empty", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/qbus_areg_block.md
Name: qbus_areg_block

Overview:
- Synchronous QBUS slave exposing `count` consecutive 16-bit read/write registers in the I/O page, starting at word address `addr`.
- Sits on the FPGA side of the QBUS driver/level-converter layer.
- All bus signals are active-high and already inverted by that layer.
- Decodes DATI, DATO(B) and DATIO(B) cycles, returns data and generates RPLY.

Parameters:
- addr, 'o17774: 13-bit I/O-page byte address of register 0; bit 0 ignored.
- count, 1: number of registers, 1..16; register n sits at addr+2n.
- init, 'o123456: reset value of every register.

Ports:
- clk  in  1  system clock, ≥50 MHz
- reset  in  1  synchronous, active-high
- DALtx  out  1  high = block drives DAL onto the bus
- DAL  inout  22  shared data/address lines; driven only when DALtx=1, else high-Z
- TRPLY  out  1  reply to master
- RDIN  in  1  bus DIN
- RDOUT  in  1  bus DOUT
- RSYNC  in  1  bus SYNC
- RBS7  in  1  bus BS7 (I/O page)
- RWTBT  in  1  bus WTBT (byte write during data phase)

Behaviour:
- Reset:
  - Registers load init.
  - DALtx=0, TRPLY=0, DAL released.
  - FSM goes to IDLE; selection is cleared.
  - Reset mid-cycle aborts the cycle immediately.
- Input synchronisation:
  - RSYNC, RDIN, RDOUT, RBS7 and RWTBT each pass through a 2-flop synchroniser.
  - Edges are detected on the synchronised copies.
  - DAL is captured into a holding register on the clock the synchronised edge is detected; the bus guarantees ≥100 ns of address hold after SYNC.
- Address phase, on a synchronised RSYNC rising edge:
  - Selected iff RBS7=1 and DAL[12:1] is in [addr[12:1], addr[12:1]+count-1].
  - DAL[21:13] are ignored, so a 16-bit address with BS7 decodes the same as a 22-bit one.
  - Selected: latch register index = DAL[12:1]-addr[12:1] and byte bit = DAL[0]; go to SEL.
  - Not selected: go to MISS. The block stays silent (no TRPLY), which the master sees as NXM.
- FSM states: IDLE, SEL, MISS, READ, WRITE.
  - From any non-IDLE state, RSYNC low → IDLE with DALtx=0, TRPLY=0.
  - SEL + DIN rise → READ:
    - Clock 1: DAL[15:0] = register, DAL[21:16]=0, DALtx=1.
    - Next clock: TRPLY=1 (data valid one clock before RPLY).
  - READ + DIN low → TRPLY=0 and DALtx=0 on the same clock → SEL. SEL permits the DOUT that follows in a DATIO cycle.
  - SEL + DOUT rise → WRITE: on that clock, write DAL[15:0] into the register, then TRPLY=1.
    - RWTBT=1 means byte write: update only the byte chosen by the latched byte bit (0 = [7:0], 1 = [15:8]) with the data from DAL[7:0] / DAL[15:8] respectively.
  - WRITE + DOUT low → TRPLY=0 → SEL.
  - DIN and DOUT rising together in SEL: DIN wins; DOUT is ignored until it is seen rising again.
  - Multiple DIN/DOUT pulses within one SYNC are all serviced against the same latched register.
- Outputs are registered. Worst-case DIN-rise-to-TRPLY is 4 clocks (80 ns at 50 MHz), which must fit within 150 ns.
- Several instances share DAL/DALtx/TRPLY by wired-OR. An unselected instance must hold DALtx=0 and TRPLY=0, and must keep DAL high-Z at all times.

Test Plan:
- Reset, then DATI to 17777774 with BS7 → TRPLY within 150 ns of DIN, DAL=123456.
- DATI to 17777770 (no register there) → TRPLY stays 0 and DALtx stays 0 throughout.
- DATI to 00017774 with BS7 (high bits clear) → responds with 123456.
- DATO 054321 to 17777774, then DATI from 17777774 → 054321. A second instance at 17772 still reads 123456.
- DATIO on 17772: read gives 123456, then DOUT with 054545 → TRPLY asserted for both phases. A subsequent DATI reads 054545.
- DATOB with WTBT on 17773, data 0o177400 → only the high byte changes. Also pulse reset mid-READ → outputs drop next clock and the register returns to init.
